// File: rtl/axisr_arb_pkg.sv
// Shared types and defaults for the packet-atomic round-robin AXI4SR arbiter.
package axisr_arb_pkg;
  localparam int DEF_N_REQ  = 4;
  localparam int STAT_CNT_W = 32;

  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_grant, modulo N_REQ.
module rr_pick
  import axisr_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] last_grant,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  localparam logic [SRC_W:0] NQ = (SRC_W+1)'(N_REQ);

  logic [SRC_W:0]   sum;
  logic [SRC_W-1:0] sel;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    sel     = '0;
    // Farthest offset first so the nearest requester after last_grant is the last write.
    for (int k = N_REQ; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (SRC_W+1)'(k);
      if (sum >= NQ) sum = sum - NQ;
      sel = sum[SRC_W-1:0];
      if (req[sel]) begin
        gnt_idx = sel;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axisr_pkt_arbiter.sv
// Packet-atomic round-robin arbiter muxing N_REQ AXI4SR streams onto one engine port.
// Optional per-requester packet counters with `define ARB_STATS_EN.
module axisr_pkt_arbiter
  import axisr_arb_pkg::*;
#(
  parameter  int N_REQ            = DEF_N_REQ,
  parameter  int AXIS_TDATA_WIDTH = 512,
  parameter  int TID_WIDTH        = 6,
  localparam int SRC_W            = $clog2(N_REQ),
  localparam int KEEP_W           = AXIS_TDATA_WIDTH/8
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [N_REQ-1:0]                    req_en,
  input  logic [N_REQ-1:0]                    s_tvalid,
  output logic [N_REQ-1:0]                    s_tready,
  input  logic [N_REQ*AXIS_TDATA_WIDTH-1:0]   s_tdata,
  input  logic [N_REQ*KEEP_W-1:0]             s_tkeep,
  input  logic [N_REQ*TID_WIDTH-1:0]          s_tid,
  input  logic [N_REQ-1:0]                    s_tlast,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_W-1:0]                   m_tkeep,
  output logic [TID_WIDTH-1:0]                m_tid,
  output logic                                m_tlast,
  output logic [SRC_W-1:0]                    m_src,
`ifdef ARB_STATS_EN
  input  logic                                stat_clr,
  output logic [N_REQ*STAT_CNT_W-1:0]         stat_pkt_cnt,
`endif
  output logic                                busy
);
  arb_state_t       state;
  logic [SRC_W-1:0] grant, last_grant;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_vld;
  logic             locked, xfer_last;

  logic [N_REQ-1:0][AXIS_TDATA_WIDTH-1:0] data_a;
  logic [N_REQ-1:0][KEEP_W-1:0]           keep_a;
  logic [N_REQ-1:0][TID_WIDTH-1:0]        tid_a;

  assign data_a = s_tdata;
  assign keep_a = s_tkeep;
  assign tid_a  = s_tid;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (s_tvalid & req_en),
    .last_grant (last_grant),
    .gnt_idx    (pick_idx),
    .gnt_vld    (pick_vld)
  );

  // Zero-latency path: the granted source is wired straight through while LOCKED.
  always_comb begin
    locked          = (state == LOCKED);
    m_tvalid        = locked & s_tvalid[grant];
    m_tdata         = data_a[grant];
    m_tkeep         = keep_a[grant];
    m_tid           = tid_a[grant];
    m_tlast         = s_tlast[grant];
    s_tready        = '0;
    s_tready[grant] = locked & m_tready;
    xfer_last       = m_tvalid & m_tready & m_tlast;
  end

  assign m_src = grant;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(N_REQ-1);
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant <= pick_idx;
          state <= LOCKED;
          busy  <= 1'b1;
        end
        LOCKED: if (xfer_last) begin
          last_grant <= grant;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][STAT_CNT_W-1:0] cnt_q;

  // Clear takes priority over a same-cycle tlast; counters wrap naturally.
  always_ff @(posedge aclk) begin
    if (areset || stat_clr) begin
      cnt_q <= '0;
    end else if (xfer_last) begin
      for (int i = 0; i < N_REQ; i++)
        if (grant == SRC_W'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign stat_pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_axisr_pkt_arbiter.sv
// Randomized scoreboard bench for axisr_pkt_arbiter against a spec-level arbitration model.
module tb_axisr_pkt_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int KW = W/8;
  localparam int TW = 6;
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic [TW-1:0] tid;
    logic          last;
  } beat_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [N-1:0]      req_en = '1;
  logic [N-1:0]      s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0]    s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N*TW-1:0]   s_tid;
  logic              m_tvalid, m_tlast, busy;
  logic              m_tready = 1'b0;
  logic [W-1:0]      m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [TW-1:0]     m_tid;
  logic [SW-1:0]     m_src;
`ifdef ARB_STATS_EN
  logic              stat_clr = 1'b0;
  logic [N*32-1:0]   stat_pkt_cnt;
  logic [31:0]       mcnt [N];
`endif

  axisr_pkt_arbiter #(.N_REQ(N), .AXIS_TDATA_WIDTH(W), .TID_WIDTH(TW)) dut (
    .aclk(aclk), .areset(areset), .req_en(req_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tid(s_tid), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tid(m_tid), .m_tlast(m_tlast), .m_src(m_src),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stat_pkt_cnt(stat_pkt_cnt),
`endif
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Source-side state: queued beats per requester and the beat currently presented.
  logic [N-1:0] tb_vld = '0;
  logic [N-1:0] acc = '0;
  beat_t        tb_beat [N];
  beat_t        pending [N][$];
  beat_t        sbq     [N][$];

  int total = 0, bad = 0, cyc = 0;
  int gen_pct = 0, vld_pct = 100, rdy_mode = 0, maxlen = 1, clr_pct = 0;
  logic [N-1:0] gen_mask = '0, vld_mask = '1;
  bit   rst_next = 1'b1, en_rand = 1'b0, done = 1'b0;

  always_comb begin
    s_tvalid = tb_vld;
    s_tdata = '0; s_tkeep = '0; s_tid = '0; s_tlast = '0;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*W +: W]   = tb_beat[i].data;
      s_tkeep[i*KW +: KW] = tb_beat[i].keep;
      s_tid[i*TW +: TW]   = tb_beat[i].tid;
      s_tlast[i]          = tb_beat[i].last;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic gen_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.tid  = TW'($urandom);
      b.last = (k == len-1);
      pending[src].push_back(b);
      sbq[src].push_back(b);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, handshakes sampled before the rise.
  task automatic cycle();
    @(negedge aclk);
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        pending[i].delete();
        sbq[i].delete();
      end
      tb_vld = '0;
      acc    = '0;
    end
    areset = rst_next;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pending[i].delete(0);
        tb_vld[i] = 1'b0;
      end
      if (!tb_vld[i]) begin
        if (pending[i].size() == 0 && gen_mask[i] && $urandom_range(0, 99) < gen_pct)
          gen_pkt(i, $urandom_range(1, maxlen));
        if (pending[i].size() > 0 && vld_mask[i] && $urandom_range(0, 99) < vld_pct) begin
          tb_vld[i]  = 1'b1;
          tb_beat[i] = pending[i][0];
        end
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    if (en_rand) req_en = N'($urandom);
`ifdef ARB_STATS_EN
    stat_clr = ($urandom_range(0, 99) < clr_pct);
`endif
    #3;
    acc = tb_vld & s_tready;
    cyc++;
  endtask

  // Monitor: spec-level arbitration model plus per-source scoreboard queues.
  initial begin
    bit           mlock = 1'b0, hs, found;
    int           mgrant = 0, mlast = N-1, j;
    logic [N-1:0] rq, exp_rdy;
    beat_t        eb;
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) mcnt[i] = '0;
`endif
    while (!done) begin
      @(negedge aclk);
      #3;
      hs = mlock && tb_vld[mgrant] && m_tready;
      chk("busy", 128'(busy), 128'(mlock));
      chk("m_src", 128'(m_src), 128'(mgrant));
      chk("m_tvalid", 128'(m_tvalid), 128'(mlock && tb_vld[mgrant]));
      exp_rdy = '0;
      if (mlock && m_tready) exp_rdy[mgrant] = 1'b1;
      chk("s_tready", 128'(s_tready), 128'(exp_rdy));
      if (hs) begin
        if (sbq[mgrant].size() == 0) chk("sb_underflow", 128'(1), 128'(0));
        else begin
          eb = sbq[mgrant].pop_front();
          chk("beat", 128'({m_tdata, m_tkeep, m_tid, m_tlast}), 128'(eb));
        end
      end
`ifdef ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("stat_cnt", 128'(stat_pkt_cnt[i*32 +: 32]), 128'(mcnt[i]));
      if (areset || stat_clr) for (int i = 0; i < N; i++) mcnt[i] = '0;
      else if (hs && tb_beat[mgrant].last) mcnt[mgrant] = mcnt[mgrant] + 1;
`endif
      rq = tb_vld & req_en;
      if (areset) begin
        mlock = 1'b0; mgrant = 0; mlast = N-1;
      end else if (!mlock) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (mlast + k) % N;
          if (rq[j] && !found) begin
            found = 1'b1;
            mgrant = j;
          end
        end
        mlock = found;
      end else if (hs && tb_beat[mgrant].last) begin
        mlast = mgrant;
        mlock = 1'b0;
      end
    end
  end

  initial begin
    int n;
    repeat (3) cycle();
    rst_next = 1'b0;
    // Two 2-beat packets on sources 0 and 2.
    gen_pkt(0, 2); gen_pkt(2, 2);
    repeat (10) cycle();
    // Continuous 1-beat packets on every source: strict rotation.
    gen_mask = '1; gen_pct = 100; maxlen = 1;
    repeat (24) cycle();
    gen_mask = '0;
    repeat (8) cycle();
    // Granted source stalls mid-packet while another requester waits.
    gen_pkt(1, 4);
    repeat (3) cycle();
    gen_pkt(3, 1);
    vld_mask = 4'b1101;
    repeat (3) cycle();
    vld_mask = '1;
    repeat (10) cycle();
    // 8-beat packet under alternating ready.
    rdy_mode = 1; gen_pkt(2, 8);
    repeat (24) cycle();
    // Source 2 masked out, then req_en changed every cycle.
    rdy_mode = 2; req_en = 4'b1011; gen_mask = '1; gen_pct = 40; maxlen = 5; vld_pct = 70;
    repeat (200) cycle();
    en_rand = 1'b1; clr_pct = 3;
    repeat (300) cycle();
    en_rand = 1'b0; clr_pct = 0; req_en = '1; gen_mask = '0; rdy_mode = 0; vld_pct = 100;
    repeat (80) cycle();
    // Reset on beat 3 of a 5-beat packet, then 1 and 3 compete.
    gen_pkt(0, 5);
    n = 0;
    for (int t = 0; t < 20 && n < 2; t++) begin
      cycle();
      if (acc[0]) n++;
    end
    chk("beats_before_reset", 128'(n), 128'(2));
    rst_next = 1'b1;
    cycle();
    rst_next = 1'b0;
    cycle();
    gen_pkt(1, 2); gen_pkt(3, 2);
    repeat (12) cycle();
    // Random traffic with stalls on both sides.
    gen_mask = '1; gen_pct = 30; maxlen = 6; vld_pct = 60; rdy_mode = 2; clr_pct = 2;
    repeat (300) cycle();
    gen_mask = '0; vld_pct = 100; rdy_mode = 0; clr_pct = 0;
    repeat (80) cycle();
    for (int i = 0; i < N; i++) chk("sb_left", 128'(sbq[i].size()), 128'(0));
    done = 1'b1;
    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
